// File: rtl/prog_seq_pkg.sv
// Shared types and default sizing for the program sequencer.
package prog_seq_pkg;

  localparam int unsigned DEF_NUM_PROGS = 3;
  localparam int unsigned DEF_CW        = 16;
  localparam logic [15:0] DEF_TIMEOUT   = 16'hFFFF;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RST    = 3'd1,
    S_START  = 3'd2,
    S_RUN    = 3'd3,
    S_REPORT = 3'd4,
    S_DONE   = 3'd5
  } state_t;

endpackage

// File: rtl/cycle_timer.sv
// Saturating RUN-cycle counter with a terminal-count flag at TIMEOUT-1.
module cycle_timer #(
  parameter int unsigned   CW      = 16,
  parameter logic [CW-1:0] TIMEOUT = '1
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          clr,
  input  logic          en,
  output logic [CW-1:0] count,
  output logic          tc
);

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && (count != '1)) begin
      count <= count + CW'(1);
    end
  end

  assign tc = (count == (TIMEOUT - CW'(1)));

endmodule

// File: rtl/prog_sequencer.sv
// Launches NUM_PROGS CPU programs back-to-back, times each under a watchdog,
// and reports every result on a valid/ready port.
module prog_sequencer
  import prog_seq_pkg::*;
#(
  parameter int unsigned   NUM_PROGS = DEF_NUM_PROGS,
  parameter int unsigned   RST_CYC   = 2,
  parameter int unsigned   START_CYC = 2,
  parameter int unsigned   CW        = DEF_CW,
  parameter logic [CW-1:0] TIMEOUT   = CW'(DEF_TIMEOUT),
  parameter int unsigned   PW        = $clog2(NUM_PROGS + 1)
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          Go,
  output logic          CpuReset,
  output logic          CpuStart,
  input  logic          CpuAck,
  output logic          ResVld,
  input  logic          ResRdy,
  output logic [PW-1:0] ResProg,
  output logic [CW-1:0] ResCycles,
  output logic          ResTimeout,
  output logic          Busy,
  output logic          Done
);

  localparam int unsigned PH_MAX = (RST_CYC > START_CYC) ? RST_CYC : START_CYC;
  localparam int unsigned PHW    = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;

  state_t          state, state_nxt;
  logic            go_q;
  logic [PW-1:0]   prog;
  logic [PHW-1:0]  ph;
  logic [CW-1:0]   count;
  logic            tc;
  logic            xfer;

  cycle_timer #(
    .CW      (CW),
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .Clk   (Clk),
    .Reset (Reset),
    .clr   (state == S_START),
    .en    ((state == S_RUN) && !CpuAck),
    .count (count),
    .tc    (tc)
  );

  assign xfer     = (state == S_REPORT) && ResVld && ResRdy;
  assign CpuReset = !Reset || (state == S_RST);

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (!go_q && Go) state_nxt = S_RST;
      S_RST:    if (ph == PHW'(RST_CYC - 1)) state_nxt = S_START;
      S_START:  if (ph == PHW'(START_CYC - 1)) state_nxt = S_RUN;
      S_RUN:    if (CpuAck || tc) state_nxt = S_REPORT;
      S_REPORT: if (xfer) state_nxt = (ResTimeout || (prog == PW'(NUM_PROGS - 1))) ? S_DONE : S_START;
      S_DONE:   if (!Go) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // go_q resets high so a Go level already present at reset release is not an edge.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state      <= S_IDLE;
      go_q       <= 1'b1;
      prog       <= '0;
      ph         <= '0;
      CpuStart   <= 1'b0;
      ResVld     <= 1'b0;
      ResProg    <= '0;
      ResCycles  <= '0;
      ResTimeout <= 1'b0;
      Busy       <= 1'b0;
      Done       <= 1'b0;
    end else begin
      state <= state_nxt;
      go_q  <= Go;
      ph    <= ((state_nxt == state) && ((state == S_RST) || (state == S_START))) ? ph + PHW'(1) : '0;
      if (state_nxt == S_IDLE) begin
        prog <= '0;
      end else if (xfer && (state_nxt == S_START)) begin
        prog <= prog + PW'(1);
      end
      if ((state == S_RUN) && (state_nxt == S_REPORT)) begin
        ResProg    <= prog;
        ResCycles  <= count;
        ResTimeout <= !CpuAck;
      end
      CpuStart <= (state_nxt == S_START);
      ResVld   <= (state_nxt == S_REPORT);
      Busy     <= (state_nxt != S_IDLE) && (state_nxt != S_DONE);
      Done     <= (state_nxt == S_DONE);
    end
  end

endmodule

// File: tb/tb_prog_sequencer.sv
// Directed bench for prog_sequencer: instance A uses the default watchdog, instance B TIMEOUT=8.
module tb_prog_sequencer;

  logic Clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 Clk = ~Clk;

  int checks   = 0;
  int failures = 0;

  logic        go_a = 1'b0, rdy_a = 1'b0, ack_en_a = 1'b0, ack_force_a = 1'b0;
  logic        cpurst_a, start_a, vld_a, to_a, busy_a, done_a, ack_a;
  logic [1:0]  prog_a;
  logic [15:0] cyc_a;
  logic [7:0]  rc_a = 8'd0;
  logic [1:0]  pidx_a = 2'd0;
  logic [7:0]  dly_a [4];

  logic        go_b = 1'b0, rdy_b = 1'b0, ack_en_b = 1'b0;
  logic        cpurst_b, start_b, vld_b, to_b, busy_b, done_b, ack_b;
  logic [1:0]  prog_b;
  logic [15:0] cyc_b;
  logic [7:0]  rc_b = 8'd0;
  logic [1:0]  pidx_b = 2'd0;
  logic [7:0]  dly_b [4];

  prog_sequencer dut_a (
    .Clk(Clk), .Reset(rst_n), .Go(go_a), .CpuReset(cpurst_a), .CpuStart(start_a),
    .CpuAck(ack_a), .ResVld(vld_a), .ResRdy(rdy_a), .ResProg(prog_a),
    .ResCycles(cyc_a), .ResTimeout(to_a), .Busy(busy_a), .Done(done_a)
  );

  prog_sequencer #(.TIMEOUT(16'd8)) dut_b (
    .Clk(Clk), .Reset(rst_n), .Go(go_b), .CpuReset(cpurst_b), .CpuStart(start_b),
    .CpuAck(ack_b), .ResVld(vld_b), .ResRdy(rdy_b), .ResProg(prog_b),
    .ResCycles(cyc_b), .ResTimeout(to_b), .Busy(busy_b), .Done(done_b)
  );

  // CPU models: Ack rises once dly[program] cycles have elapsed since Start fell.
  assign ack_a = ack_force_a | (ack_en_a & ~start_a & (rc_a >= dly_a[pidx_a]));
  assign ack_b = ack_en_b & ~start_b & (rc_b >= dly_b[pidx_b]);

  always @(posedge Clk) begin
    rc_a <= start_a ? 8'd0 : ((rc_a == 8'hFF) ? rc_a : rc_a + 8'd1);
    rc_b <= start_b ? 8'd0 : ((rc_b == 8'hFF) ? rc_b : rc_b + 8'd1);
    if (cpurst_a) pidx_a <= 2'd0; else if (vld_a && rdy_a) pidx_a <= pidx_a + 2'd1;
    if (cpurst_b) pidx_b <= 2'd0; else if (vld_b && rdy_b) pidx_b <= pidx_b + 2'd1;
  end

  task automatic do_reset();
    rst_n = 1'b0;
    go_a = 1'b0; go_b = 1'b0; rdy_a = 1'b0; rdy_b = 1'b0;
    ack_en_a = 1'b0; ack_en_b = 1'b0; ack_force_a = 1'b0;
    repeat (2) @(negedge Clk);
    rst_n = 1'b1;
    repeat (2) @(negedge Clk);
  endtask

  task automatic test_reset();
    @(negedge Clk);
    checks++;
    if ({cpurst_a, start_a, vld_a, to_a, busy_a, done_a} !== 6'b100000) begin
      failures++;
      $display("FAIL reset_outs got=%b want=100000", {cpurst_a, start_a, vld_a, to_a, busy_a, done_a});
    end
    checks++;
    if ({prog_a, cyc_a} !== 18'd0) begin
      failures++;
      $display("FAIL reset_res got prog=%0d cyc=%0d want 0 0", prog_a, cyc_a);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge Clk);
    for (int i = 0; i < 4; i++) dly_a[i] = 8'd20;
    ack_en_a = 1'b1; rdy_a = 1'b1; go_a = 1'b1;
    repeat (8) @(negedge Clk);
    checks++;
    if ({busy_a, start_a, cpurst_a} !== 3'b100) begin
      failures++;
      $display("FAIL midrun got busy/start/cpurst=%b want 100", {busy_a, start_a, cpurst_a});
    end
    rst_n = 1'b0;
    @(posedge Clk); #1;
    checks++;
    if ({cpurst_a, vld_a, busy_a, done_a} !== 4'b1000) begin
      failures++;
      $display("FAIL reset_midrun got cpurst/vld/busy/done=%b want 1000", {cpurst_a, vld_a, busy_a, done_a});
    end
    @(negedge Clk);
    rst_n = 1'b1;
    repeat (5) @(negedge Clk);
    checks++;
    if ({busy_a, cpurst_a} !== 2'b00) begin
      failures++;
      $display("FAIL go_level_no_start got busy/cpurst=%b want 00", {busy_a, cpurst_a});
    end
    go_a = 1'b0;
    @(negedge Clk);
    go_a = 1'b1;
    @(negedge Clk);
    checks++;
    if ({busy_a, cpurst_a} !== 2'b11) begin
      failures++;
      $display("FAIL go_edge_start got busy/cpurst=%b want 11", {busy_a, cpurst_a});
    end
    do_reset();
  endtask

  task automatic test_three_progs();
    int ec[3] = '{5, 0, 12};
    int n = 0, rstc = 0, stc = 0;
    bit fin = 0;
    dly_a[0] = 8'd5; dly_a[1] = 8'd0; dly_a[2] = 8'd12; dly_a[3] = 8'd0;
    ack_en_a = 1'b1; rdy_a = 1'b1; go_a = 1'b1;
    for (int c = 0; c < 300 && !fin; c++) begin
      @(negedge Clk);
      if (cpurst_a) rstc++;
      if (start_a) stc++;
      if (vld_a && rdy_a) begin
        checks++;
        if (n >= 3 || prog_a !== 2'(n) || cyc_a !== 16'(ec[n]) || to_a !== 1'b0) begin
          failures++;
          $display("FAIL three_res[%0d] got (%0d,%0d,%0d) want (%0d,%0d,0)", n, prog_a, cyc_a, to_a,
                   n, (n < 3) ? ec[n] : -1);
        end
        n++;
      end
      if (done_a) fin = 1;
    end
    checks++;
    if (!fin || n != 3) begin
      failures++;
      $display("FAIL three_done got done=%0d results=%0d want 1 3", fin, n);
    end
    checks++;
    if (rstc != 2 || stc != 6) begin
      failures++;
      $display("FAIL three_pulses got cpurst=%0d start=%0d cycles want 2 6", rstc, stc);
    end
    checks++;
    if (busy_a !== 1'b0) begin
      failures++;
      $display("FAIL three_busy_in_done got %b want 0", busy_a);
    end
    go_a = 1'b0;
    repeat (2) @(negedge Clk);
    checks++;
    if (done_a !== 1'b0) begin
      failures++;
      $display("FAIL done_clear got %b want 0", done_a);
    end
    do_reset();
  endtask

  task automatic test_timeout();
    int n = 0, starts = 0;
    bit fin = 0, prev = 0;
    ack_en_b = 1'b0; rdy_b = 1'b1; go_b = 1'b1;
    for (int c = 0; c < 300 && !fin; c++) begin
      @(negedge Clk);
      if (start_b && !prev) starts++;
      prev = start_b;
      if (vld_b && rdy_b) begin
        checks++;
        if (n != 0 || prog_b !== 2'd0 || cyc_b !== 16'd7 || to_b !== 1'b1) begin
          failures++;
          $display("FAIL timeout_res[%0d] got (%0d,%0d,%0d) want (0,7,1)", n, prog_b, cyc_b, to_b);
        end
        n++;
      end
      if (done_b) fin = 1;
    end
    checks++;
    if (!fin || n != 1 || starts != 1) begin
      failures++;
      $display("FAIL timeout_abort got done=%0d results=%0d starts=%0d want 1 1 1", fin, n, starts);
    end
    do_reset();
  endtask

  task automatic test_backpressure();
    bit seen = 0, fin = 0;
    for (int i = 0; i < 4; i++) dly_a[i] = 8'd3;
    ack_en_a = 1'b1; rdy_a = 1'b0; go_a = 1'b1;
    for (int c = 0; c < 100 && !seen; c++) begin
      @(negedge Clk);
      if (vld_a) seen = 1;
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL bp_vld_wait got vld=0 want 1 within 100 cycles");
    end
    for (int i = 1; i <= 5; i++) begin
      if (i > 1) @(negedge Clk);
      checks++;
      if (vld_a !== 1'b1 || prog_a !== 2'd0 || cyc_a !== 16'd3 || to_a !== 1'b0) begin
        failures++;
        $display("FAIL bp_hold[%0d] got vld=%b (%0d,%0d,%0d) want 1 (0,3,0)", i, vld_a, prog_a, cyc_a, to_a);
      end
      if (i == 5) rdy_a = 1'b1;
    end
    @(negedge Clk);
    checks++;
    if ({vld_a, start_a} !== 2'b01) begin
      failures++;
      $display("FAIL bp_next_start got vld/start=%b want 01", {vld_a, start_a});
    end
    for (int c = 0; c < 200 && !fin; c++) begin
      @(negedge Clk);
      if (done_a) fin = 1;
    end
    checks++;
    if (!fin) begin
      failures++;
      $display("FAIL bp_done got done=0 want 1 within 200 cycles");
    end
    do_reset();
  endtask

  task automatic test_ack_at_tc();
    int n = 0;
    bit fin = 0;
    for (int i = 0; i < 4; i++) dly_b[i] = 8'd7;
    ack_en_b = 1'b1; rdy_b = 1'b1; go_b = 1'b1;
    for (int c = 0; c < 300 && !fin; c++) begin
      @(negedge Clk);
      if (vld_b && rdy_b) begin
        checks++;
        if (n >= 3 || prog_b !== 2'(n) || cyc_b !== 16'd7 || to_b !== 1'b0) begin
          failures++;
          $display("FAIL acktc_res[%0d] got (%0d,%0d,%0d) want (%0d,7,0)", n, prog_b, cyc_b, to_b, n);
        end
        n++;
      end
      if (done_b) fin = 1;
    end
    checks++;
    if (!fin || n != 3) begin
      failures++;
      $display("FAIL acktc_count got done=%0d results=%0d want 1 3", fin, n);
    end
    do_reset();
  endtask

  task automatic test_ack_in_start();
    int n = 0, w = 0, pulses = 0;
    bit fin = 0, prev = 0;
    ack_force_a = 1'b1; rdy_a = 1'b1; go_a = 1'b1;
    for (int c = 0; c < 300 && !fin; c++) begin
      @(negedge Clk);
      if (start_a) begin
        w++;
      end else if (prev) begin
        checks++;
        if (w != 2) begin
          failures++;
          $display("FAIL start_width[%0d] got %0d want 2", pulses, w);
        end
        pulses++;
        w = 0;
      end
      prev = start_a;
      if (vld_a && rdy_a) begin
        checks++;
        if (n >= 3 || prog_a !== 2'(n) || cyc_a !== 16'd0 || to_a !== 1'b0) begin
          failures++;
          $display("FAIL ackstart_res[%0d] got (%0d,%0d,%0d) want (%0d,0,0)", n, prog_a, cyc_a, to_a, n);
        end
        n++;
      end
      if (done_a) fin = 1;
    end
    checks++;
    if (!fin || n != 3 || pulses != 3) begin
      failures++;
      $display("FAIL ackstart_count got done=%0d results=%0d pulses=%0d want 1 3 3", fin, n, pulses);
    end
    do_reset();
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      dly_a[i] = 8'd0;
      dly_b[i] = 8'd0;
    end
    test_reset();
    test_three_progs();
    test_timeout();
    test_backpressure();
    test_ack_at_tc();
    test_ack_in_start();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
